sbit_tap_scanner: RTL and testbench
===================================

// Module: sbit_tap_scanner
// PURPOSE
// Sequencer for the oversampler IODELAY tap inputs. Shares one scan engine across NUM_CH
// oversampled trigger links: per enabled channel, sweeps tap 0..31, counts phase_err per
// tap, finds the longest clean tap window and parks the tap at its centre. Sits between
// slow control (start/mask/dwell) and the oversampler tap_delay_i inputs.
// PARAMETERS
// NUM_CH      8   number of oversampler channels served
// DWELL_W     16  width of dwell counter / dwell_i
// SETTLE_CYC  4   cycles waited after each tap change before counting (tap reg + IODELAY load)
// PORTS
// clock        in   1          logic clock (same clock as oversampler tap registers)
// reset_n      in   1          asynchronous, active-low reset
// start_i      in   1          pulse: begin scan of all channels in ch_mask_i
// ch_mask_i    in   NUM_CH     1 = scan channel; sampled on accepted start_i
// dwell_i      in   DWELL_W    cycles phase_err is observed per tap; 0 treated as 1
// phase_err_i  in   NUM_CH     per-channel phase_err, already synchronised to clock
// tap_delay_o  out  NUM_CH*5   tap per channel, ch k at [5k+4:5k]
// cur_ch_o     out  3          channel under scan (index width = clog2(NUM_CH))
// busy_o       out  1          high from accepted start_i until done_o
// done_o       out  1          one-cycle pulse at scan end
// fail_o       out  NUM_CH     1 = channel had no clean tap in last scan
// BEHAVIOUR
// - Reset: tap_delay_o=0 all ch, cur_ch_o=0, busy_o=0, done_o=0, fail_o=0, state IDLE.
// - FSM: IDLE -> SETTLE -> DWELL -> EVAL -> (SETTLE | CENTER) -> NEXT_CH -> (SETTLE | DONE) -> IDLE.
// - IDLE: start_i latches mask/dwell; mask==0 -> DONE directly. start_i while busy ignored.
// - Channel entry: save prior tap, clear fail bit, tap=0, run/best trackers cleared.
// - SETTLE: SETTLE_CYC cycles, phase_err ignored. DWELL: D=max(dwell_i,1) cycles, err flag
//   sets if phase_err_i[cur_ch] high on any of them. EVAL (1 cycle): tap good iff flag clear.
// - Run tracking: good tap extends cur run (start=tap if len was 0); bad tap ends it. best
//   updated only when cur_len > best_len (strict: ties keep lowest-start window). No wrap
//   between tap 31 and 0. tap 31 ends the sweep -> CENTER.
// - CENTER: best_len==0 -> fail bit=1, tap restored to saved value; else
//   tap = best_start + ((best_len-1)>>1) (5-bit, never exceeds 31).
// - NEXT_CH: advance to next masked index ascending; none left -> DONE (done_o pulse, busy_o 0).
// - Only cur channel's tap field changes during scan; others hold.
// - Per-tap cost SETTLE_CYC+D+1 cycles; per channel 32*(SETTLE_CYC+D+1)+2.
// - Async reset mid-scan: immediate return to reset values (scanned taps lost).
// CONFIGURATION
// - TAP_SCAN_ERR_THRESH_EN defined: adds input err_thresh_i [7:0]; DWELL counts error
//   cycles (8-bit saturating); tap good iff count <= err_thresh_i.
// - Not defined: no port; tap good iff zero error cycles (as above).
// TESTING
// - mask=1, dwell=8, ch0 errors on taps 0-5 and 20-31 -> tap_delay_o[4:0]=12, fail_o=0, done_o 1 pulse.
// - ch0 error on every tap, prior tap 7 -> fail_o[0]=1, tap stays 7.
// - ch0 never errors -> tap 15; busy_o high exactly 32*(4+8+1)+2+1 cycles.
// - clean windows 2-5 and 10-13 (equal len) -> tap 3 (tie keeps first).
// - mask=8'b1010_0000, ch5 clean 8-16 -> ch5=12, ch7 scanned next, ch0-4,6 taps unchanged;
//   start_i re-pulsed mid-scan ignored.
// - reset_n low during ch7 DWELL -> all taps 0, busy_o 0 same cycle; macro on, thresh=2,
//   tap 4 with 2 error cycles counts as good.

Source files
------------

// File: rtl/sbit_tap_scanner_if.sv
// Slow-control / oversampler bundle for sbit_tap_scanner.
// Optional macro TAP_SCAN_ERR_THRESH_EN adds the err_thresh_i input.
interface sbit_tap_scanner_if #(
  parameter int NUM_CH  = 8,
  parameter int DWELL_W = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                  start_i;
  logic [NUM_CH-1:0]     ch_mask_i;
  logic [DWELL_W-1:0]    dwell_i;
  logic [NUM_CH-1:0]     phase_err_i;
`ifdef TAP_SCAN_ERR_THRESH_EN
  logic [7:0]            err_thresh_i;
`endif
  logic [NUM_CH*5-1:0]   tap_delay_o;
  logic [CH_W-1:0]       cur_ch_o;
  logic                  busy_o;
  logic                  done_o;
  logic [NUM_CH-1:0]     fail_o;

`ifdef TAP_SCAN_ERR_THRESH_EN
  modport master (output start_i, ch_mask_i, dwell_i, phase_err_i, err_thresh_i,
                  input  tap_delay_o, cur_ch_o, busy_o, done_o, fail_o);
  modport slave  (input  start_i, ch_mask_i, dwell_i, phase_err_i, err_thresh_i,
                  output tap_delay_o, cur_ch_o, busy_o, done_o, fail_o);
`else
  modport master (output start_i, ch_mask_i, dwell_i, phase_err_i,
                  input  tap_delay_o, cur_ch_o, busy_o, done_o, fail_o);
  modport slave  (input  start_i, ch_mask_i, dwell_i, phase_err_i,
                  output tap_delay_o, cur_ch_o, busy_o, done_o, fail_o);
`endif
endinterface

// File: rtl/sbit_tap_scanner.sv
// Shared IODELAY tap scan engine: per masked channel sweeps tap 0..31, finds the
// longest clean tap window and parks the tap at its centre.
// Optional macro TAP_SCAN_ERR_THRESH_EN: a tap is good when its saturating 8-bit
// error-cycle count is <= err_thresh_i instead of requiring zero errors.
module sbit_tap_scanner #(
  parameter int NUM_CH     = 8,
  parameter int DWELL_W    = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  sbit_tap_scanner_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DWELL_W-1:0] SETTLE_LAST = DWELL_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_DWELL, S_EVAL, S_CENTER, S_NEXT_CH, S_DONE
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [NUM_CH-1:0][4:0]  r_tap;
  logic [NUM_CH-1:0]       r_fail, r_mask;
  logic [CH_W-1:0]         r_cur_ch;
  logic [DWELL_W-1:0]      r_cnt, r_dwell_last;
  logic [4:0]              r_saved;
  logic [5:0]              r_cur_len, r_best_len;
  logic [4:0]              r_cur_start, r_best_start;
`ifdef TAP_SCAN_ERR_THRESH_EN
  logic [7:0]              r_err_cnt;
`else
  logic                    r_err;
`endif

  logic [CH_W-1:0] w_first, w_next, w_entry_ch;
  logic            w_has_next, w_entry, w_good, w_err_bit;
  logic [4:0]      w_tap, w_run_start, w_center;
  logic [5:0]      w_run_len, w_half;

  assign w_tap       = r_tap[r_cur_ch];
  assign w_err_bit   = bus.phase_err_i[r_cur_ch];
  assign w_run_len   = r_cur_len + 6'd1;
  assign w_run_start = (r_cur_len == 6'd0) ? w_tap : r_cur_start;
  assign w_half      = (r_best_len - 6'd1) >> 1;
  assign w_center    = r_best_start + w_half[4:0];
`ifdef TAP_SCAN_ERR_THRESH_EN
  assign w_good      = (r_err_cnt <= bus.err_thresh_i);
`else
  assign w_good      = ~r_err;
`endif

  // Lowest channel in the incoming mask, and next masked channel above the current one
  always_comb begin
    w_first    = '0;
    w_next     = '0;
    w_has_next = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (bus.ch_mask_i[k]) w_first = CH_W'(k);
      if (r_mask[k] && (k > int'(r_cur_ch))) begin
        w_next     = CH_W'(k);
        w_has_next = 1'b1;
      end
    end
  end

  assign w_entry    = ((r_state == S_IDLE) && bus.start_i && (|bus.ch_mask_i)) ||
                      ((r_state == S_NEXT_CH) && w_has_next);
  assign w_entry_ch = (r_state == S_IDLE) ? w_first : w_next;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.start_i) w_state_nxt = (|bus.ch_mask_i) ? S_SETTLE : S_DONE;
      S_SETTLE:  if (r_cnt == SETTLE_LAST) w_state_nxt = S_DWELL;
      S_DWELL:   if (r_cnt == r_dwell_last) w_state_nxt = S_EVAL;
      S_EVAL:    w_state_nxt = (w_tap == 5'd31) ? S_CENTER : S_SETTLE;
      S_CENTER:  w_state_nxt = S_NEXT_CH;
      S_NEXT_CH: w_state_nxt = w_has_next ? S_SETTLE : S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Scan datapath: counters, error accumulation, run tracking, tap updates
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tap        <= '0;
      r_fail       <= '0;
      r_mask       <= '0;
      r_cur_ch     <= '0;
      r_cnt        <= '0;
      r_dwell_last <= '0;
      r_saved      <= '0;
      r_cur_len    <= '0;
      r_best_len   <= '0;
      r_cur_start  <= '0;
      r_best_start <= '0;
`ifdef TAP_SCAN_ERR_THRESH_EN
      r_err_cnt    <= '0;
`else
      r_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (bus.start_i) begin
          r_mask       <= bus.ch_mask_i;
          // dwell of 0 behaves as 1 cycle
          r_dwell_last <= (bus.dwell_i == '0) ? '0 : bus.dwell_i - 1'b1;
        end
        S_SETTLE: if (r_cnt == SETTLE_LAST) begin
          r_cnt <= '0;
`ifdef TAP_SCAN_ERR_THRESH_EN
          r_err_cnt <= '0;
`else
          r_err     <= 1'b0;
`endif
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_DWELL: begin
          r_cnt <= (r_cnt == r_dwell_last) ? '0 : r_cnt + 1'b1;
`ifdef TAP_SCAN_ERR_THRESH_EN
          if (w_err_bit && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
`else
          if (w_err_bit) r_err <= 1'b1;
`endif
        end
        S_EVAL: begin
          // strict compare: an equal-length later window never displaces the first
          if (w_good) begin
            r_cur_len   <= w_run_len;
            r_cur_start <= w_run_start;
            if (w_run_len > r_best_len) begin
              r_best_len   <= w_run_len;
              r_best_start <= w_run_start;
            end
          end else begin
            r_cur_len <= '0;
          end
          if (w_tap != 5'd31) r_tap[r_cur_ch] <= w_tap + 5'd1;
        end
        S_CENTER: begin
          if (r_best_len == 6'd0) begin
            r_fail[r_cur_ch] <= 1'b1;
            r_tap[r_cur_ch]  <= r_saved;
          end else begin
            r_tap[r_cur_ch]  <= w_center;
          end
        end
        default: ;
      endcase

      if (w_entry) begin
        r_cur_ch            <= w_entry_ch;
        r_saved             <= r_tap[w_entry_ch];
        r_tap[w_entry_ch]   <= 5'd0;
        r_fail[w_entry_ch]  <= 1'b0;
        r_cnt               <= '0;
        r_cur_len           <= '0;
        r_cur_start         <= '0;
        r_best_len          <= '0;
        r_best_start        <= '0;
      end
    end
  end

  assign bus.tap_delay_o = r_tap;
  assign bus.cur_ch_o    = r_cur_ch;
  assign bus.fail_o      = r_fail;
  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.done_o      = (r_state == S_DONE);
endmodule

// File: tb/tb_sbit_tap_scanner.sv
// Randomised bench for sbit_tap_scanner with a window-enumerating reference model.
module tb_sbit_tap_scanner;
  localparam int NCH = 8, DW = 16, SC = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sbit_tap_scanner_if #(.NUM_CH(NCH), .DWELL_W(DW)) bus ();
  sbit_tap_scanner #(.NUM_CH(NCH), .DWELL_W(DW), .SETTLE_CYC(SC)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));

  logic [31:0]      bad [NCH];
  logic [4:0]       exp_tap [NCH];
  logic [NCH-1:0]   exp_fail;
  bit               noise_en;
  int               n_checks, n_pass;

  // Link model: a bad tap errors every cycle; other channels may chatter randomly
  always @(negedge clock) begin
    for (int k = 0; k < NCH; k++)
      bus.phase_err_i[k] = bad[k][bus.tap_delay_o[5*k +: 5]] |
        (noise_en && (k != int'(bus.cur_ch_o)) && ($urandom_range(0, 1) == 1));
  end

  // Longest fully clean window, lowest start on ties, centre = start + (len-1)/2
  function automatic void model_scan(input logic [31:0] b, input logic [4:0] prior,
                                     output logic [4:0] tap, output logic fail);
    int best_l, best_s;
    bit clean;
    best_l = 0; best_s = 0;
    for (int a = 0; a < 32; a++)
      for (int e = a; e < 32; e++) begin
        clean = 1'b1;
        for (int t = a; t <= e; t++) if (b[t]) clean = 1'b0;
        if (clean && (e - a + 1) > best_l) begin best_l = e - a + 1; best_s = a; end
      end
    if (best_l == 0) begin fail = 1'b1; tap = prior; end
    else begin fail = 1'b0; tap = 5'(best_s + (best_l - 1) / 2); end
  endfunction

  function automatic void apply_model(input logic [7:0] m);
    logic [4:0] t;
    logic f;
    for (int c = 0; c < NCH; c++)
      if (m[c]) begin
        model_scan(bad[c], exp_tap[c], t, f);
        exp_tap[c] = t;
        exp_fail[c] = f;
      end
  endfunction

  function automatic logic [NCH*5-1:0] exp_vec();
    logic [NCH*5-1:0] v;
    for (int c = 0; c < NCH; c++) v[5*c +: 5] = exp_tap[c];
    return v;
  endfunction

  function automatic int exp_busy(input logic [7:0] m, input int d);
    int n, dm;
    n = $countones(m);
    dm = (d == 0) ? 1 : d;
    return n * (32 * (SC + dm + 1) + 2) + 1;
  endfunction

  // Pulse start, then count busy/done cycles until the scan ends (bounded)
  task automatic do_scan(input logic [7:0] m, input int d, input int repulse,
                         output int busy_cyc, output int dones, output bit tmo);
    bit seen;
    busy_cyc = 0; dones = 0; seen = 0;
    @(negedge clock);
    bus.ch_mask_i = m; bus.dwell_i = 16'(d); bus.start_i = 1'b1;
    @(negedge clock);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (cyc == repulse) begin bus.start_i = 1'b1; bus.ch_mask_i = 8'hFF; end
      else bus.start_i = 1'b0;
      if (seen && !bus.busy_o) break;
      if (bus.busy_o) busy_cyc++;
      if (bus.done_o) begin dones++; seen = 1; end
      @(negedge clock);
    end
    bus.start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.done_o) dones++;
      @(negedge clock);
    end
    tmo = !seen;
  endtask

  task automatic test_reset();
    bus.start_i = 0; bus.ch_mask_i = 0; bus.dwell_i = 0; noise_en = 0;
`ifdef TAP_SCAN_ERR_THRESH_EN
    bus.err_thresh_i = 8'd0;
`endif
    for (int c = 0; c < NCH; c++) begin bad[c] = 32'h0; exp_tap[c] = 5'd0; end
    exp_fail = '0;
    repeat (3) @(negedge clock);
    n_checks++; if (bus.tap_delay_o !== '0) $display("FAIL reset tap: got %h want 0", bus.tap_delay_o); else n_pass++;
    n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL reset busy: got %b want 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.done_o !== 1'b0) $display("FAIL reset done: got %b want 0", bus.done_o); else n_pass++;
    n_checks++; if (bus.fail_o !== '0) $display("FAIL reset fail: got %b want 0", bus.fail_o); else n_pass++;
    n_checks++; if (bus.cur_ch_o !== 3'd0) $display("FAIL reset cur_ch: got %0d want 0", bus.cur_ch_o); else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_spec_window();
    int b, dn; bit tmo;
    bad[0] = 32'hFFF0_003F;
    apply_model(8'h01);
    do_scan(8'h01, 8, -1, b, dn, tmo);
    n_checks++; if (tmo) $display("FAIL window timeout: no done_o"); else n_pass++;
    n_checks++; if (bus.tap_delay_o[4:0] !== 5'd12) $display("FAIL window tap0: got %0d want 12", bus.tap_delay_o[4:0]); else n_pass++;
    n_checks++; if (bus.fail_o[0] !== 1'b0) $display("FAIL window fail0: got %b want 0", bus.fail_o[0]); else n_pass++;
    n_checks++; if (dn !== 1) $display("FAIL window done pulses: got %0d want 1", dn); else n_pass++;
  endtask

  task automatic test_all_bad();
    int b, dn; bit tmo;
    bad[0] = 32'hFFFF_8000;
    apply_model(8'h01);
    do_scan(8'h01, 3, -1, b, dn, tmo);
    n_checks++; if (bus.tap_delay_o[4:0] !== 5'd7) $display("FAIL allbad prior tap: got %0d want 7", bus.tap_delay_o[4:0]); else n_pass++;
    bad[0] = 32'hFFFF_FFFF;
    apply_model(8'h01);
    do_scan(8'h01, 3, -1, b, dn, tmo);
    n_checks++; if (bus.fail_o[0] !== 1'b1) $display("FAIL allbad fail0: got %b want 1", bus.fail_o[0]); else n_pass++;
    n_checks++; if (bus.tap_delay_o[4:0] !== 5'd7) $display("FAIL allbad tap restore: got %0d want 7", bus.tap_delay_o[4:0]); else n_pass++;
  endtask

  task automatic test_clean_busy();
    int b, dn; bit tmo;
    bad[0] = 32'h0;
    apply_model(8'h01);
    do_scan(8'h01, 8, -1, b, dn, tmo);
    n_checks++; if (b !== 419) $display("FAIL clean busy cycles: got %0d want 419", b); else n_pass++;
    n_checks++; if (bus.tap_delay_o[4:0] !== 5'd15) $display("FAIL clean tap0: got %0d want 15", bus.tap_delay_o[4:0]); else n_pass++;
    n_checks++; if (bus.fail_o[0] !== 1'b0) $display("FAIL clean fail0: got %b want 0", bus.fail_o[0]); else n_pass++;
  endtask

  task automatic test_tie();
    int b, dn; bit tmo;
    bad[0] = ~(32'h0000_003C | 32'h0000_3C00);
    apply_model(8'h01);
    do_scan(8'h01, 2, -1, b, dn, tmo);
    n_checks++; if (bus.tap_delay_o[4:0] !== 5'd3) $display("FAIL tie tap0: got %0d want 3", bus.tap_delay_o[4:0]); else n_pass++;
  endtask

  task automatic test_two_ch();
    int b, dn; bit tmo;
    bad[5] = ~32'h0001_FF00;
    bad[7] = $urandom;
    noise_en = 1;
    apply_model(8'hA0);
    do_scan(8'hA0, 8, 200, b, dn, tmo);
    noise_en = 0;
    n_checks++; if (bus.tap_delay_o[29:25] !== 5'd12) $display("FAIL twoch tap5: got %0d want 12", bus.tap_delay_o[29:25]); else n_pass++;
    n_checks++; if (bus.tap_delay_o !== exp_vec()) $display("FAIL twoch taps: got %h want %h", bus.tap_delay_o, exp_vec()); else n_pass++;
    n_checks++; if (bus.fail_o !== exp_fail) $display("FAIL twoch fail: got %b want %b", bus.fail_o, exp_fail); else n_pass++;
    n_checks++; if (b !== exp_busy(8'hA0, 8)) $display("FAIL twoch busy (restart ignored): got %0d want %0d", b, exp_busy(8'hA0, 8)); else n_pass++;
    n_checks++; if (bus.cur_ch_o !== 3'd7) $display("FAIL twoch last ch: got %0d want 7", bus.cur_ch_o); else n_pass++;
  endtask

  task automatic test_zero_mask();
    int b, dn; bit tmo;
    do_scan(8'h00, 5, -1, b, dn, tmo);
    n_checks++; if (dn !== 1 || b !== 1) $display("FAIL zeromask done/busy: got %0d/%0d want 1/1", dn, b); else n_pass++;
    n_checks++; if (bus.tap_delay_o !== exp_vec()) $display("FAIL zeromask taps: got %h want %h", bus.tap_delay_o, exp_vec()); else n_pass++;
  endtask

  task automatic test_dwell_zero();
    int b, dn; bit tmo;
    bad[1] = $urandom & $urandom;
    apply_model(8'h02);
    do_scan(8'h02, 0, -1, b, dn, tmo);
    n_checks++; if (b !== 195) $display("FAIL dwell0 busy: got %0d want 195", b); else n_pass++;
    n_checks++; if (bus.tap_delay_o !== exp_vec()) $display("FAIL dwell0 taps: got %h want %h", bus.tap_delay_o, exp_vec()); else n_pass++;
  endtask

  task automatic test_random();
    int b, dn, d; bit tmo;
    logic [7:0] m;
    for (int it = 0; it < 5; it++) begin
      for (int c = 0; c < NCH; c++)
        case ($urandom_range(0, 3))
          0: bad[c] = 32'hFFFF_FFFF;
          1: bad[c] = $urandom & $urandom & $urandom;
          2: bad[c] = $urandom;
          default: bad[c] = 32'h0;
        endcase
      m = 8'($urandom);
      d = $urandom_range(0, 3);
      noise_en = 1;
      apply_model(m);
      do_scan(m, d, $urandom_range(5, 100), b, dn, tmo);
      noise_en = 0;
      n_checks++; if (bus.tap_delay_o !== exp_vec()) $display("FAIL random%0d taps: got %h want %h", it, bus.tap_delay_o, exp_vec()); else n_pass++;
      n_checks++; if (bus.fail_o !== exp_fail) $display("FAIL random%0d fail: got %b want %b", it, bus.fail_o, exp_fail); else n_pass++;
      n_checks++; if (b !== exp_busy(m, d) || dn !== 1) $display("FAIL random%0d busy/done: got %0d/%0d want %0d/1", it, b, dn, exp_busy(m, d)); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 0;
    bad[5] = 32'hFF00_00FF;
    bad[7] = 32'h0000_0F0F;
    @(negedge clock);
    bus.ch_mask_i = 8'hA0; bus.dwell_i = 16'd4; bus.start_i = 1'b1;
    @(negedge clock);
    bus.start_i = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (bus.cur_ch_o == 3'd7) begin found = 1; break; end
      @(negedge clock);
    end
    n_checks++; if (!found) $display("FAIL midreset reach ch7: timed out"); else n_pass++;
    repeat (SC + 1) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (bus.tap_delay_o !== '0) $display("FAIL midreset taps: got %h want 0", bus.tap_delay_o); else n_pass++;
    n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL midreset busy: got %b want 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.fail_o !== '0 || bus.cur_ch_o !== 3'd0) $display("FAIL midreset fail/cur_ch: got %b/%0d want 0/0", bus.fail_o, bus.cur_ch_o); else n_pass++;
    for (int c = 0; c < NCH; c++) begin exp_tap[c] = 5'd0; bad[c] = 32'h0; end
    exp_fail = '0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

`ifdef TAP_SCAN_ERR_THRESH_EN
  task automatic test_thresh();
    int b, dn; bit tmo;
    bad[0] = 32'hFFFF_FFFF;
    bus.err_thresh_i = 8'd2;
    do_scan(8'h01, 2, -1, b, dn, tmo);
    n_checks++; if (bus.tap_delay_o[4:0] !== 5'd15 || bus.fail_o[0] !== 1'b0) $display("FAIL thresh2 tap/fail: got %0d/%b want 15/0", bus.tap_delay_o[4:0], bus.fail_o[0]); else n_pass++;
    bus.err_thresh_i = 8'd1;
    do_scan(8'h01, 2, -1, b, dn, tmo);
    n_checks++; if (bus.tap_delay_o[4:0] !== 5'd15 || bus.fail_o[0] !== 1'b1) $display("FAIL thresh1 tap/fail: got %0d/%b want 15/1", bus.tap_delay_o[4:0], bus.fail_o[0]); else n_pass++;
    bus.err_thresh_i = 8'd0;
  endtask
`endif

  initial begin
    n_checks = 0; n_pass = 0;
    test_reset();
    test_spec_window();
    test_all_bad();
    test_clean_busy();
    test_tie();
    test_two_ch();
    test_zero_mask();
    test_dwell_zero();
    test_random();
    test_reset_mid();
`ifdef TAP_SCAN_ERR_THRESH_EN
    test_thresh();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
